// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
// Contents:
//   div_state_t - FSM state encoding (IDLE, RUN, FIX, DONE)
//   cnt_width   - width of the iteration counter for an M-bit divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // The counter must be able to hold M itself, so it needs ceil(log2(M+1)) bits.
  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// One combinational (M+1)-bit add/subtract step of the non-restoring divider.
// Ports:
//   i_p        - current partial remainder P (M+1 bits, two's complement)
//   i_d        - divisor D (M bits, unsigned)
//   i_q_bit_in - bit shifted into P from the top of Q during an iteration
//   i_fix      - 1: remainder correction, P + {0,D} with no shift
//                0: iteration, S = {P[M-1:0], q_in}, S -/+ {0,D} chosen by P[M]
//   o_p_new    - resulting partial remainder (carry-out dropped)
//   o_q_bit    - quotient bit, 1 when the result is non-negative
module nr_div_step #(
  parameter int M = 32
) (
  input  logic [M:0]   i_p,
  input  logic [M-1:0] i_d,
  input  logic         i_q_bit_in,
  input  logic         i_fix,
  output logic [M:0]   o_p_new,
  output logic         o_q_bit
);

  logic       w_sub;
  logic [M:0] w_a;
  logic [M:0] w_b;

  // Subtract when the partial remainder is non-negative; correction only adds.
  assign w_sub = i_fix ? 1'b0 : ~i_p[M];
  assign w_a   = i_fix ? i_p : {i_p[M-1:0], i_q_bit_in};
  // Subtraction as a + ~b + 1, carry-in equal to the subtract select.
  assign w_b   = {1'b0, i_d} ^ {(M + 1){w_sub}};

  // The intermediate shifted value may overflow M+1 bits, but the result
  // always lies in (-D, D), so arithmetic modulo 2^(M+1) is exact.
  assign o_p_new = w_a + w_b + {{M{1'b0}}, w_sub};
  assign o_q_bit = ~o_p_new[M];

endmodule

// File: rtl/seq_div_nonrestoring.sv
// Multi-cycle unsigned M-bit non-restoring divider with valid/ready on both sides.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake; in_ready is high only in IDLE
//   x, y                - dividend, divisor (sampled on the accepting edge)
//   out_valid/out_ready - result handshake; result held until accepted
//   q, r, dz            - quotient, remainder, divide-by-zero flag
//   dbg_state           - current FSM state for observation
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a valid side keeps its data stable until that edge, and the
// ready side may not depend combinationally on valid.
module seq_div_nonrestoring
  import div_pkg::*;
#(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] q,
  output logic [M-1:0] r,
  output logic         dz,
  output div_state_t   dbg_state
);

  localparam int            CW       = cnt_width(M);
  localparam logic [CW-1:0] CNT_INIT = CW'(M);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  div_state_t    r_state;
  logic [M:0]    r_p;
  logic [M-1:0]  r_q;
  logic [M-1:0]  r_d;
  logic [CW-1:0] r_cnt;
  logic [M-1:0]  r_q_out;
  logic [M-1:0]  r_r_out;
  logic          r_dz;
  logic          r_in_ready;
  logic          r_out_valid;

  logic [M:0]    w_p_new;
  logic          w_q_bit;
  logic          w_fix;
  logic [M-1:0]  w_r_fix;

  assign w_fix = (r_state == FIX);

  nr_div_step #(.M(M)) u_step (
    .i_p        (r_p),
    .i_d        (r_d),
    .i_q_bit_in (r_q[M-1]),
    .i_fix      (w_fix),
    .o_p_new    (w_p_new),
    .o_q_bit    (w_q_bit)
  );

  // A negative final partial remainder is one divisor short of the true remainder.
  assign w_r_fix = r_p[M] ? w_p_new[M-1:0] : r_p[M-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_p         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_q_out     <= '0;
      r_r_out     <= '0;
      r_dz        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (y == '0) begin
              // Divide by zero bypasses the datapath entirely.
              r_q_out     <= '1;
              r_r_out     <= x;
              r_dz        <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_p     <= '0;
              r_q     <= x;
              r_d     <= y;
              r_cnt   <= CNT_INIT;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_p   <= w_p_new;
          r_q   <= {r_q[M-2:0], w_q_bit};
          r_cnt <= r_cnt - CNT_LAST;
          if (r_cnt == CNT_LAST) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_p         <= r_p[M] ? w_p_new : r_p;
          r_q_out     <= r_q;
          r_r_out     <= w_r_fix;
          r_dz        <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign q         = r_q_out;
  assign r         = r_r_out;
  assign dz        = r_dz;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_div_nonrestoring.sv
// Self-checking bench for seq_div_nonrestoring (M=32).
module tb_seq_div_nonrestoring;
  import div_pkg::*;

  localparam int M = 32;
  localparam int LAT_DIV = M + 2;
  localparam int LAT_DZ  = 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] x;
  logic [M-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] q;
  logic [M-1:0] r;
  logic         dz;
  div_state_t   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [M-1:0] exp_q[$];
  logic [M-1:0] exp_r[$];
  logic         exp_dz[$];
  int           exp_lat[$];

  seq_div_nonrestoring #(.M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dz        (dz),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // Waits for in_ready, presents operands for one accepting edge, and pushes
  // the reference result (plain / and % in the bench) when requested.
  task automatic send(input logic [M-1:0] xv, input logic [M-1:0] yv, input bit push);
    int waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
    end
    x = xv;
    y = yv;
    in_valid = 1'b1;
    if (push) begin
      exp_q.push_back(yv == '0 ? {M{1'b1}} : xv / yv);
      exp_r.push_back(yv == '0 ? xv : xv % yv);
      exp_dz.push_back(yv == '0);
      exp_lat.push_back(yv == '0 ? LAT_DZ : LAT_DIV);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge after the accepting edge (edge 1); counts edges
  // until out_valid is seen, bounded.
  task automatic get_result(output int lat, output bit timed_out);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    timed_out = !out_valid;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, q, r, dz} !== {1'b1, 1'b0, {M{1'b0}}, {M{1'b0}}, 1'b0}
        || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_values: in_ready=%0b out_valid=%0b q=%h r=%h dz=%0b state=%0d required 1 0 0 0 0 IDLE",
               in_ready, out_valid, q, r, dz, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; bit to;
    logic [M-1:0] eq, er; logic ed; int el;
    send(32'd100, 32'd7, 1'b1);
    get_result(lat, to);
    eq = exp_q.pop_front(); er = exp_r.pop_front(); ed = exp_dz.pop_front(); el = exp_lat.pop_front();
    n_checks++;
    if (to || lat != el) begin
      n_fail++;
      $display("FAIL basic_latency: got edge %0d (timeout=%0b) required %0d", lat, to, el);
    end
    n_checks++;
    if ({q, r, dz} !== {eq, er, ed} || {q, r} !== {32'd14, 32'd2}) begin
      n_fail++;
      $display("FAIL basic_result: q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b", q, r, dz, eq, er, ed);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready_in_done: in_ready=%0b required 0", in_ready);
    end
    accept();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_handshake: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
    n_checks++;
    if ({q, r, dz} !== {eq, er, ed}) begin
      n_fail++;
      $display("FAIL basic_hold_in_idle: q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b", q, r, dz, eq, er, ed);
    end
  endtask

  // Boundary operand table including divide-by-zero and a follow-up division.
  task automatic test_boundaries();
    logic [M-1:0] tx[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'h80000000, 32'd5, 32'd9, 32'd0};
    logic [M-1:0] ty[7] = '{32'd1, 32'hFFFFFFFF, 32'd10, 32'h80000001, 32'd0, 32'd4, 32'd0};
    int lat; bit to;
    logic [M-1:0] eq, er; logic ed; int el;
    for (int i = 0; i < 7; i++) begin
      send(tx[i], ty[i], 1'b1);
      get_result(lat, to);
      eq = exp_q.pop_front(); er = exp_r.pop_front(); ed = exp_dz.pop_front(); el = exp_lat.pop_front();
      n_checks++;
      if (to || lat != el) begin
        n_fail++;
        $display("FAIL bound_latency[%0d]: got edge %0d (timeout=%0b) required %0d", i, lat, to, el);
      end
      n_checks++;
      if ({q, r, dz} !== {eq, er, ed}) begin
        n_fail++;
        $display("FAIL bound_result[%0d] x=%h y=%h: q=%h r=%h dz=%0b required q=%h r=%h dz=%0b",
                 i, tx[i], ty[i], q, r, dz, eq, er, ed);
      end
      accept();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    logic [M-1:0] eq, er; logic ed; int el;
    logic [M-1:0] hq, hr; logic hd;
    send(32'd77, 32'd6, 1'b1);
    get_result(lat, to);
    eq = exp_q.pop_front(); er = exp_r.pop_front(); ed = exp_dz.pop_front(); el = exp_lat.pop_front();
    n_checks++;
    if (to || {q, r, dz} !== {eq, er, ed}) begin
      n_fail++;
      $display("FAIL bp_first_result: q=%0d r=%0d dz=%0b timeout=%0b required q=%0d r=%0d dz=%0b", q, r, dz, to, eq, er, ed);
    end
    hq = q; hr = r; hd = dz;
    x = 32'd50; y = 32'd8; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({q, r, dz} !== {hq, hr, hd} || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: q=%0d r=%0d dz=%0b in_ready=%0b out_valid=%0b required q=%0d r=%0d dz=%0b 0 1",
                 c, q, r, dz, in_ready, out_valid, hq, hr, hd);
      end
    end
    accept();
    n_checks++;
    if (in_ready !== 1'b1 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL bp_not_captured: in_ready=%0b state=%0d required 1 IDLE", in_ready, dbg_state);
    end
    exp_q.push_back(32'd6); exp_r.push_back(32'd2); exp_dz.push_back(1'b0); exp_lat.push_back(LAT_DIV);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (dbg_state !== RUN || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept_after_idle: state=%0d in_ready=%0b required RUN 0", dbg_state, in_ready);
    end
    get_result(lat, to);
    eq = exp_q.pop_front(); er = exp_r.pop_front(); ed = exp_dz.pop_front(); el = exp_lat.pop_front();
    n_checks++;
    if (to || lat != el || {q, r, dz} !== {eq, er, ed}) begin
      n_fail++;
      $display("FAIL bp_second_result: q=%0d r=%0d dz=%0b lat=%0d required q=%0d r=%0d dz=%0b lat=%0d",
               q, r, dz, lat, eq, er, ed, el);
    end
    accept();
  endtask

  task automatic test_reset_mid_run();
    int lat; bit to; bit seen;
    logic [M-1:0] eq, er; logic ed; int el;
    send(32'd123456, 32'd789, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (dbg_state !== IDLE || in_ready !== 1'b1 || out_valid !== 1'b0 || q !== '0 || r !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_run: state=%0d in_ready=%0b out_valid=%0b q=%h r=%h required IDLE 1 0 0 0",
               dbg_state, in_ready, out_valid, q, r);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_discard: out_valid seen=1 required 0");
    end
    send(32'd1000, 32'd33, 1'b1);
    get_result(lat, to);
    eq = exp_q.pop_front(); er = exp_r.pop_front(); ed = exp_dz.pop_front(); el = exp_lat.pop_front();
    n_checks++;
    if (to || lat != el || {q, r, dz} !== {eq, er, ed} || {q, r} !== {32'd30, 32'd10}) begin
      n_fail++;
      $display("FAIL rst_then_div: q=%0d r=%0d dz=%0b lat=%0d required q=%0d r=%0d dz=%0b lat=%0d",
               q, r, dz, lat, eq, er, ed, el);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    logic [M-1:0] xv, yv;
    logic [M-1:0] eq, er; logic ed; int el;
    for (int i = 0; i < 8; i++) begin
      xv = $urandom();
      yv = $urandom() >> $urandom_range(0, 31);
      if (i == 3) yv = '0;
      send(xv, yv, 1'b1);
      get_result(lat, to);
      eq = exp_q.pop_front(); er = exp_r.pop_front(); ed = exp_dz.pop_front(); el = exp_lat.pop_front();
      n_checks++;
      if (to || lat != el || {q, r, dz} !== {eq, er, ed}) begin
        n_fail++;
        $display("FAIL b2b[%0d] x=%h y=%h: q=%h r=%h dz=%0b lat=%0d required q=%h r=%h dz=%0b lat=%0d",
                 i, xv, yv, q, r, dz, lat, eq, er, ed, el);
      end
      accept();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
